// File: rtl/clk_sched_if.sv
// Handshake/status bundle between the MCU core and the clock-enable scheduler.
// The idle request/acknowledge pair exists only when CLKSCHED_IDLE_EN is defined.
interface clk_sched_if #(
  parameter int CNT_W = 5
);
  logic             run;
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic [CNT_W-1:0] cur_div;
  logic             clk_en;
  logic [3:0]       phase;
  logic             mc_start;
`ifdef CLKSCHED_IDLE_EN
  logic             idle_req;
  logic             idle_ack;

  modport master (
    output run, div_req, div_val, idle_req,
    input  div_ack, div_err, cur_div, clk_en, phase, mc_start, idle_ack
  );

  modport slave (
    input  run, div_req, div_val, idle_req,
    output div_ack, div_err, cur_div, clk_en, phase, mc_start, idle_ack
  );
`else
  modport master (
    output run, div_req, div_val,
    input  div_ack, div_err, cur_div, clk_en, phase, mc_start
  );

  modport slave (
    input  run, div_req, div_val,
    output div_ack, div_err, cur_div, clk_en, phase, mc_start
  );
`endif
endinterface

// File: rtl/clk_en_sched.sv
// Programmable clock-enable scheduler: divides clk_in by cur_div, emits one clk_en
// tick per period and steps the 8051 12-phase machine cycle on every tick.
// Divisor changes are accepted only on a period boundary (or while stopped), so a
// running period is never cut short.
// Optional feature macro: CLKSCHED_IDLE_EN adds an idle request/acknowledge pair
// that parks the scheduler after a completed machine cycle (phase 11 tick).
module clk_en_sched #(
  parameter int CNT_W       = 5,
  parameter int DEFAULT_DIV = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  clk_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       PH_LAST = 4'd11;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             clk_en_q, clk_en_d;
  logic [3:0]       phase_q, phase_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;

  logic             run_eff_s;
  logic             tick_s;
  logic             upd_s;

`ifdef CLKSCHED_IDLE_EN
  logic             idle_ack_q, idle_ack_d;
  logic             idle_enter_s;

  // Park after a tick that closed the machine cycle; leave one cycle after idle_req drops.
  always_comb begin
    idle_enter_s = bus.idle_req & clk_en_q & (phase_q == PH_LAST) & ~idle_ack_q;
    if (idle_ack_q) begin
      idle_ack_d = bus.idle_req;
    end else begin
      idle_ack_d = idle_enter_s;
    end
  end

  assign run_eff_s    = bus.run & ~idle_ack_q & ~idle_enter_s;
  assign bus.idle_ack = idle_ack_q;
`else
  assign run_eff_s    = bus.run;
`endif

  // Period boundary detection and divisor-update acceptance window.
  always_comb begin
    tick_s = run_eff_s & (cnt_q == (cur_div_q - CNT_ONE));
    upd_s  = bus.div_req & ~div_ack_q & (tick_s | ~run_eff_s);
  end

  // Next-state for counter, tick, phase and the divisor handshake.
  always_comb begin
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    clk_en_d  = tick_s;
    phase_d   = phase_q;
    div_ack_d = upd_s;
    div_err_d = 1'b0;

    if (tick_s) begin
      cnt_d   = {CNT_W{1'b0}};
      phase_d = (phase_q == PH_LAST) ? 4'd0 : (phase_q + 4'd1);
    end else if (run_eff_s) begin
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      cnt_d   = {CNT_W{1'b0}};
    end

    if (upd_s) begin
      if (bus.div_val == {CNT_W{1'b0}}) begin
        // Zero divisor is rejected; counting continues on the old divisor.
        div_err_d = 1'b1;
      end else begin
        cur_div_d = bus.div_val;
        cnt_d     = {CNT_W{1'b0}};
      end
    end else begin
      div_err_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      cur_div_q  <= DIV_RST;
      clk_en_q   <= 1'b0;
      phase_q    <= PH_LAST;
      div_ack_q  <= 1'b0;
      div_err_q  <= 1'b0;
`ifdef CLKSCHED_IDLE_EN
      idle_ack_q <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      clk_en_q   <= clk_en_d;
      phase_q    <= phase_d;
      div_ack_q  <= div_ack_d;
      div_err_q  <= div_err_d;
`ifdef CLKSCHED_IDLE_EN
      idle_ack_q <= idle_ack_d;
`endif
    end
  end

  assign bus.div_ack  = div_ack_q;
  assign bus.div_err  = div_err_q;
  assign bus.cur_div  = cur_div_q;
  assign bus.clk_en   = clk_en_q;
  assign bus.phase    = phase_q;
  assign bus.mc_start = clk_en_q & (phase_q == 4'd0);

endmodule

// File: tb/tb_clk_en_sched.sv
// Randomized self-checking bench for clk_en_sched (default build, no idle feature).
// A cycle-level reference model built from the period/tick rules predicts every
// output; directed sequences cover reset, the DEFAULT_DIV tick train and reset with
// a pending divisor request.
module tb_clk_en_sched;

  localparam int CNT_W   = 5;
  localparam int DEF_DIV = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clk_sched_if #(.CNT_W(CNT_W)) bus ();

  clk_en_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

`ifdef CLKSCHED_IDLE_EN
  initial bus.idle_req = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: cycles elapsed in the current period, divisor, phase, pulses.
  int m_elapsed;
  int m_div;
  int m_phase;
  int m_en;
  int m_ack;
  int m_err;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_elapsed = 0;
    m_div     = DEF_DIV;
    m_phase   = 11;
    m_en      = 0;
    m_ack     = 0;
    m_err     = 0;
  endtask

  // One clock of the scheduler rules: a period is m_div running cycles long.
  task automatic model_step(input int r, input int rq, input int v, input int rs);
    int boundary;
    int apply;
    if (rs != 0) begin
      model_reset();
      return;
    end
    boundary = (r != 0 && (m_elapsed + 1) == m_div) ? 1 : 0;
    apply    = (rq != 0 && m_ack == 0 && (boundary != 0 || r == 0)) ? 1 : 0;
    m_en     = boundary;
    if (boundary != 0) m_phase = (m_phase + 1) % 12;
    if (boundary != 0 || r == 0) m_elapsed = 0;
    else m_elapsed = m_elapsed + 1;
    m_ack = apply;
    m_err = (apply != 0 && v == 0) ? 1 : 0;
    if (apply != 0 && v != 0) begin
      m_div     = v;
      m_elapsed = 0;
    end
  endtask

  task automatic compare_all();
    check("cur_div",  int'(bus.cur_div),  m_div);
    check("clk_en",   int'(bus.clk_en),   m_en);
    check("phase",    int'(bus.phase),    m_phase);
    check("div_ack",  int'(bus.div_ack),  m_ack);
    check("div_err",  int'(bus.div_err),  m_err);
    check("mc_start", int'(bus.mc_start), (m_en != 0 && m_phase == 0) ? 1 : 0);
  endtask

  // Advance one clock: model consumes the inputs present at the edge, outputs sampled 1 later.
  task automatic cycle();
    model_step(int'(bus.run), int'(bus.div_req), int'(bus.div_val), int'(rst));
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int req_on;
    int req_age;
    int req_lim;
    int prev_rst;
    int v;

    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = '0;
    model_reset();
    cycle();
    cycle();

    // Reset values against fixed constants.
    check("rst_phase",   int'(bus.phase),   11);
    check("rst_cur_div", int'(bus.cur_div), DEF_DIV);
    check("rst_clk_en",  int'(bus.clk_en),  0);
    check("rst_div_ack", int'(bus.div_ack), 0);

    // DEFAULT_DIV tick train: ticks on edges 2,4,6..; mc_start on 1st and 13th tick.
    rst     = 1'b0;
    bus.run = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      cycle();
      check("t1_clk_en", int'(bus.clk_en), (i % 2 == 0) ? 1 : 0);
      check("t1_mc_start", int'(bus.mc_start), (i == 2 || i == 26) ? 1 : 0);
      if (i % 2 == 0) check("t1_phase", int'(bus.phase), (i / 2 - 1) % 12);
    end

    // Reset with a divisor request pending: no ack, divisor back to default.
    bus.div_req = 1'b1;
    bus.div_val = CNT_W'(7);
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_no_ack",  int'(bus.div_ack), 0);
    check("t6_cur_div", int'(bus.cur_div), DEF_DIV);
    check("t6_phase",   int'(bus.phase),   11);
    check("t6_clk_en",  int'(bus.clk_en),  0);
    rst         = 1'b0;
    bus.div_req = 1'b0;

    // Randomized traffic: run toggles, divisor requests (including 0 and 1), rare resets.
    req_on   = 0;
    req_age  = 0;
    req_lim  = 0;
    prev_rst = 0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (prev_rst != 0) begin
        req_on      = 0;
        bus.div_req = 1'b0;
      end else if (req_on != 0) begin
        req_age++;
        if (bus.div_ack == 1'b1) begin
          check("req_latency_ok", (req_age <= req_lim) ? 1 : 0, 1);
          req_on      = 0;
          bus.div_req = 1'b0;
        end else if (req_age > 40) begin
          check("req_lost_age", req_age, 0);
          req_on      = 0;
          bus.div_req = 1'b0;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 31));
        else v = int'($urandom_range(0, 6));
        req_on      = 1;
        req_age     = 0;
        req_lim     = m_div;
        bus.div_val = CNT_W'(v);
        bus.div_req = 1'b1;
      end
      prev_rst = int'(rst);
      rst      = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 24) == 0) bus.run = ~bus.run;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
